// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame controller slice.
//   fft_state_e : controller FSM states (FILL, COMPUTE, DRAIN)
//   idx_width() : index width for a frame of SIZE points (log2(SIZE), min 1)
package fft_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } fft_state_e;

  function automatic int unsigned idx_width(input int unsigned size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Sample buffer plus the shared frame index.
// The index addresses buffer writes while filling and selects result bins
// while draining, so the controller steps it in both phases.
// Ports:
//   clk, rst_n  : clock, async active-low reset (clears index and buffer)
//   clr_i       : return index to 0 (takes priority over inc_i)
//   inc_i       : advance index by one
//   wr_en_i     : write wr_data_i into entry [idx_o]
//   wr_data_i   : sample to store
//   idx_o       : current index
//   mem_o       : whole buffer, entry i at mem_o[i]
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned IN_BITS = 32,
  parameter int unsigned IDX_W   = idx_width(SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic                             inc_i,
  input  logic                             wr_en_i,
  input  logic [IN_BITS-1:0]               wr_data_i,
  output logic [IDX_W-1:0]                 idx_o,
  output logic [SIZE-1:0][IN_BITS-1:0]     mem_o
);

  logic [IDX_W-1:0]             idx_q;
  logic [SIZE-1:0][IN_BITS-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      idx_q <= '0;
    else if (clr_i)  idx_q <= '0;
    else if (inc_i)  idx_q <= idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mem_q        <= '0;
    else if (wr_en_i)  mem_q[idx_q] <= wr_data_i;
  end

  assign idx_o = idx_q;
  assign mem_o = mem_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller around an external FFT core: collects SIZE samples,
// presents them to the core, waits CORE_LAT settle cycles, captures the
// results and streams them out one bin per handshake.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   flush                 : synchronous abort back to FILL (buffers retained)
//   in_valid/in_ready/in_data : sample stream (accepted only in FILL)
//   core_in               : frame to the core, entry i = sample i
//   core_re/core_im       : core results, entry i = bin i
//   out_valid/out_ready   : result handshake
//   out_re/out_im/out_idx : current bin value and index
//   out_last              : final bin of the frame
//   busy                  : high in COMPUTE or DRAIN
//   frame_cnt             : completed-frame count, only with
//                           FFT_FRAME_CTRL_FRAME_CNT_EN defined
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned IN_BITS  = 32,
  parameter int unsigned OUT_BITS = 32,
  parameter int unsigned CORE_LAT = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_BITS-1:0]                in_data,
  output logic [SIZE-1:0][IN_BITS-1:0]      core_in,
  input  logic [SIZE-1:0][OUT_BITS-1:0]     core_re,
  input  logic [SIZE-1:0][OUT_BITS-1:0]     core_im,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [idx_width(SIZE)-1:0]        out_idx,
  output logic [OUT_BITS-1:0]               out_re,
  output logic [OUT_BITS-1:0]               out_im,
  output logic                              out_last,
  output logic                              busy
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]                       frame_cnt
`endif
);

  localparam int unsigned      IDX_W    = idx_width(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [3:0]       LAT      = 4'(CORE_LAT);

  fft_state_e                    state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [SIZE-1:0][OUT_BITS-1:0] res_re_q, res_im_q;
  logic                          capture;
  logic                          idx_clr, idx_inc, wr_en;
  logic [IDX_W-1:0]              idx;

  fft_frame_buf #(
    .SIZE    (SIZE),
    .IN_BITS (IN_BITS),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (idx_clr),
    .inc_i     (idx_inc),
    .wr_en_i   (wr_en),
    .wr_data_i (in_data),
    .idx_o     (idx),
    .mem_o     (core_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_re_q <= '0;
      res_im_q <= '0;
    end else if (capture) begin
      res_re_q <= core_re;
      res_im_q <= core_im;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    wr_en   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            state_d = ST_COMPUTE;
            idx_clr = 1'b1;
            cnt_d   = '0;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == LAT) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_d = ST_FILL;
            idx_clr = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
    // Flush overrides whatever the state logic decided, including a
    // same-cycle sample write or result capture.
    if (flush) begin
      state_d = ST_FILL;
      cnt_d   = '0;
      idx_clr = 1'b1;
      idx_inc = 1'b0;
      wr_en   = 1'b0;
      capture = 1'b0;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign busy      = (state_q != ST_FILL);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_idx   = out_valid ? idx : '0;
  assign out_re    = out_valid ? res_re_q[idx] : '0;
  assign out_im    = out_valid ? res_im_q[idx] : '0;
  assign out_last  = out_valid && (idx == LAST_IDX);

`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt_q <= '0;
    else if (out_valid && out_ready && out_last && !flush)
      frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int SIZE     = 8;
  localparam int IN_BITS  = 32;
  localparam int OUT_BITS = 32;
  localparam int CORE_LAT = 2;
  localparam real PI      = 3.14159265358979323846;

  typedef int frame_t [SIZE];
  typedef logic [SIZE-1:0][31:0] packed_frame_t;

  logic                          clk;
  logic                          rst_n;
  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [IN_BITS-1:0]            in_data;
  logic [SIZE-1:0][IN_BITS-1:0]  core_in;
  logic [SIZE-1:0][OUT_BITS-1:0] core_re;
  logic [SIZE-1:0][OUT_BITS-1:0] core_im;
  logic                          out_valid;
  logic                          out_ready;
  logic [idx_width(SIZE)-1:0]    out_idx;
  logic [OUT_BITS-1:0]           out_re;
  logic [OUT_BITS-1:0]           out_im;
  logic                          out_last;
  logic                          busy;
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
  logic [15:0]                   frame_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int frames_done = 0;

  fft_frame_ctrl #(
    .SIZE     (SIZE),
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .core_in   (core_in),
    .core_re   (core_re),
    .core_im   (core_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct DFT of a real frame, rounded to nearest integer.
  function automatic int dft_bin(input packed_frame_t f, input int k, input bit want_im);
    real acc;
    real ang;
    real x;
    acc = 0.0;
    for (int n = 0; n < SIZE; n++) begin
      ang = 2.0 * PI * $itor(k * n) / $itor(SIZE);
      x   = $itor($signed(f[n]));
      if (want_im) acc = acc - x * $sin(ang);
      else         acc = acc + x * $cos(ang);
    end
    if (acc >= 0.0) return $rtoi(acc + 0.5);
    else            return -$rtoi(-acc + 0.5);
  endfunction

  // FFT core stand-in: combinational transform of whatever the controller presents.
  always_comb begin
    core_re = '0;
    core_im = '0;
    for (int k = 0; k < SIZE; k++) begin
      core_re[k] = dft_bin(core_in, k, 1'b0);
      core_im[k] = dft_bin(core_in, k, 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t s;
    for (int i = 0; i < SIZE; i++) s[i] = int'($urandom_range(0, 1000));
    return s;
  endfunction

  // Offer the first n samples of s; each waits (bounded) for in_ready.
  task automatic push(input frame_t s, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      w = 0;
      while (!in_ready && w < 64) begin
        @(posedge clk); #1;
        w++;
      end
      if (w == 64) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int c;
    c = 0;
    while (!out_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("latency", 32'(c), 32'(CORE_LAT + 1));
  endtask

  // Consume bins 0..stop_at-1 of the frame s (all bins when stop_at == SIZE).
  task automatic drain(input frame_t s, input bit stall, input int stop_at);
    packed_frame_t f;
    int  st;
    bit  done;
    for (int i = 0; i < SIZE; i++) f[i] = s[i];
    for (int b = 0; b < SIZE; b++) begin
      if (b == stop_at) return;
      st   = 0;
      done = 1'b0;
      while (!done) begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_idx",   32'(out_idx),   32'(b));
        check("out_re",    out_re,         dft_bin(f, b, 1'b0));
        check("out_im",    out_im,         dft_bin(f, b, 1'b1));
        check("out_last",  32'(out_last),  32'(b == SIZE - 1));
        check("in_ready_drain", 32'(in_ready), 32'd0);
        check("busy_drain", 32'(busy), 32'd1);
        if (stall && st < 5) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = 1'b1;
        if (out_ready) done = 1'b1;
        else           st++;
        @(posedge clk); #1;
      end
    end
    frames_done++;
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic check_frame_cnt(input string tag);
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    check(tag, 32'(frame_cnt), 32'(frames_done & 16'hFFFF));
`else
    n_checks = n_checks + 0;
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    frame_t s, a, b;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_re",    out_re,         32'd0);
    check("rst_out_im",    out_im,         32'd0);
    check("rst_core_in",   32'(core_in == '0), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Ramp 1..8, no stalls.
    for (int i = 0; i < SIZE; i++) s[i] = i + 1;
    push(s, SIZE);
    wait_valid();
    drain(s, 1'b0, SIZE);
    check_frame_cnt("frame_cnt_1");

    // Random frames with random output stalls.
    repeat (3) begin
      s = rand_frame();
      push(s, SIZE);
      wait_valid();
      drain(s, 1'b1, SIZE);
    end
    check_frame_cnt("frame_cnt_4");

    // Flush after 5 samples (same-cycle sample must be dropped), then 10..17.
    s = rand_frame();
    push(s, 5);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd999;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy",     32'(busy),     32'd0);
    check_frame_cnt("frame_cnt_flush_fill");
    for (int i = 0; i < SIZE; i++) s[i] = 10 + i;
    push(s, SIZE);
    wait_valid();
    drain(s, 1'b0, SIZE);

    // Flush during COMPUTE: no results may appear.
    s = rand_frame();
    push(s, SIZE);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (CORE_LAT + 3) begin
      check("flush_compute_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Flush during DRAIN after two bins.
    s = rand_frame();
    push(s, SIZE);
    wait_valid();
    drain(s, 1'b0, 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_drain_valid", 32'(out_valid), 32'd0);
    check("flush_drain_ready", 32'(in_ready),  32'd1);
    check("flush_drain_idx",   32'(out_idx),   32'd0);
    check_frame_cnt("frame_cnt_flush_drain");

    // Async reset mid-drain at bin 3.
    s = rand_frame();
    push(s, SIZE);
    wait_valid();
    drain(s, 1'b1, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_re",    out_re,         32'd0);
    check("arst_out_im",    out_im,         32'd0);
    check("arst_out_idx",   32'(out_idx),   32'd0);
    check("arst_out_last",  32'(out_last),  32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    frames_done = 0;
    check_frame_cnt("frame_cnt_arst");
    @(negedge clk) rst_n = 1'b1;
    s = rand_frame();
    push(s, SIZE);
    wait_valid();
    drain(s, 1'b1, SIZE);

    // Back-to-back: next frame's first sample is offered throughout the drain.
    a = rand_frame();
    b = rand_frame();
    push(a, SIZE);
    wait_valid();
    in_valid = 1'b1;
    in_data  = b[0];
    drain(a, 1'b0, SIZE);
    push(b, SIZE);
    wait_valid();
    drain(b, 1'b0, SIZE);
    check_frame_cnt("frame_cnt_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8: points per frame, power of two, >= 2.
REQ-002 SHALL have parameter IN_BITS, default 32: input sample width.
REQ-003 SHALL have parameter OUT_BITS, default 32: real/imaginary result width.
REQ-004 SHALL have parameter CORE_LAT, default 0: settle cycles allowed for the attached FFT core, 0..15.
REQ-005 SHALL have ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- flush  in  1: synchronous abort.
- in_valid  in  1 / in_ready  out  1 / in_data  in  IN_BITS: sample stream.
- core_in  out  IN_BITS x SIZE: frame presented to the FFT core.
- core_re, core_im  in  OUT_BITS x SIZE: core results.
- out_valid  out  1 / out_ready  in  1: result stream handshake.
- out_re, out_im  out  OUT_BITS: result word.
- out_idx  out  log2(SIZE): bin index.
- out_last  out  1: final bin of frame.
- busy  out  1: high in COMPUTE or DRAIN.

Function
REQ-006 SHALL implement FSM states FILL, COMPUTE, DRAIN; reset state FILL.
REQ-007 FILL: in_ready=1; each in_valid&&in_ready writes buf[idx], then idx++.
REQ-008 FILL: handshake at idx==SIZE-1 SHALL go to COMPUTE with idx=0 and wait counter=0.
REQ-009 core_in SHALL be driven continuously from buf, in natural index order.
REQ-010 COMPUTE: in_ready=0; counter increments each cycle.
REQ-011 COMPUTE at counter==CORE_LAT: SHALL capture core_re/core_im into result registers and go to DRAIN; out_valid first rises CORE_LAT+1 cycles after the last input handshake.
REQ-012 DRAIN: out_valid=1; out_re/out_im=res[idx]; out_idx=idx; out_last=(idx==SIZE-1).
REQ-013 Outputs SHALL hold stable while out_valid&&!out_ready.
REQ-014 DRAIN: on handshake, idx++; the handshake with out_last SHALL go to FILL with idx=0; there SHALL be no bubble, so in_ready=1 on the next cycle.
REQ-015 in_ready SHALL be 0 and input SHALL be ignored outside FILL; no input is accepted while draining.
REQ-016 flush SHALL take priority over every handshake: the next state is FILL, idx=0, counter=0, out_valid=0, and buf/res are retained.
REQ-017 A flush in FILL SHALL discard the partial frame; a handshake in the same cycle is not written.
REQ-018 idx SHALL never exceed SIZE-1; no wrap occurs except via the transitions above.

Reset
REQ-019 While rst_n=0, SHALL force: state FILL, idx 0, counter 0, buf and res all 0; in_ready 1; out_valid, out_last, busy, out_idx, out_re, out_im all 0.
REQ-020 Reset assertion mid-frame or mid-drain SHALL abort immediately without waiting for clk.
REQ-021 First acceptance SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-022 Macro FFT_FRAME_CTRL_FRAME_CNT_EN:
- Defined: adds output frame_cnt (16 bits, reset 0), which increments on each out_last handshake and wraps at 65535->0; flush does not change it.
- Undefined: no port and no counter logic.

Structure
REQ-023 Shared package fft_pkg SHALL hold the FSM state enum and the index-width constant/function (log2(SIZE)).
REQ-024 The sample buffer plus write index SHALL be the sub-module fft_frame_buf; the FSM, counter and result registers stay in fft_frame_ctrl.

Verification (SIZE=8, CORE_LAT=2, core model = reference FFT)
REQ-025 Inputs 1..8 with no stalls -> out_valid rises 3 cycles after 8th handshake; 8 outputs equal reference FFT of [1..8]; out_last only on idx 7.
REQ-026 Random out_ready stalls during DRAIN -> out_re/out_im/out_idx held while stalled; order 0..7 preserved; in_ready=0 throughout.
REQ-027 flush after 5 samples, then samples 10..17 -> outputs equal FFT of [10..17]; no earlier data visible.
REQ-028 rst_n pulsed low mid-DRAIN at idx 3 -> all outputs 0 asynchronously; in_ready=1; next frame processes correctly.
REQ-029 Back-to-back frames with out_ready=1 and in_valid=1 -> in_ready high one cycle after final out_last; no lost samples.
REQ-030 With FFT_FRAME_CTRL_FRAME_CNT_EN: 3 frames -> frame_cnt=3; a flush mid-frame leaves frame_cnt unchanged.
